gray_count_decoder: RTL and testbench
=====================================

# gray_count_decoder

Receive-side companion to the Gray counter: samples a Gray-coded count, possibly from another clock domain, through a synchronizer chain and converts it to binary. It reports the per-cycle increment and counter wrap, and flags illegal multi-bit Gray transitions. It sits at the consumer end of any Gray-coded pointer or counter link, such as FIFO pointers or event counters.

## Interface
- `WIDTH`, default 4: count width in bits, ≥ 2.
- `SYNC_STAGES`, default 2: synchronizer flops ahead of the decode stage, ≥ 1.

- `clk`  input  1: single clock; all flops on the rising edge.
- `reset`  input  1: asynchronous, active-high reset.
- `gray_in`  input  WIDTH: Gray-coded count, asynchronous to `clk`.
- `clr_err`  input  1: synchronous clear of `jump_err`.
- `gray_sync`  output  WIDTH: last synchronizer stage, registered.
- `bin_out`  output  WIDTH: binary decode of the sample, registered.
- `bin_valid`  output  1: `bin_out` holds a real sample.
- `delta`  output  WIDTH: (`bin_out` − previous `bin_out`) mod 2^WIDTH.
- `inc`  output  1: `delta` == 1 this cycle.
- `wrap`  output  1: one-cycle pulse when `bin_out` goes from all-ones to zero.
- `jump_err`  output  1: sticky flag for an illegal Gray transition.

## Operation
- **Reset**
  - Asserting `reset` asynchronously clears every flop: sync chain, `gray_sync`, `bin_out`, `delta`, `inc`, `wrap`, `jump_err`, `bin_valid`, the fill counter and the first-sample flag.
  - All outputs read 0 while `reset` is high.
- **Synchronizer:** `gray_in` shifts through SYNC_STAGES flops. The last flop drives `gray_sync`. No logic sits between stages.
- **Decode**
  - b[W−1] = g[W−1].
  - b[i] = b[i+1] XOR g[i].
  - Computed combinationally from `gray_sync` and registered into `bin_out`.
- **Fill counter**
  - Counts rising edges after reset deassertion, saturating at SYNC_STAGES+1.
  - `bin_valid` goes to 1 when the count reaches SYNC_STAGES+1 and stays 1 until reset.
- **First valid sample**
  - `delta` = 0, `inc` = 0, `wrap` = 0.
  - No error check.
  - Sets an internal `have_prev` flag.
- **Subsequent samples**, each cycle with `have_prev` = 1:
  - `delta` = new_bin − `bin_out`, truncated to WIDTH.
  - `inc` = (`delta` == 1).
  - `wrap` = (`bin_out` == all-ones AND new_bin == 0).
- **Steady input:** `delta` = 0, `inc` = 0, `wrap` = 0.
- **Error check**
  - Popcount of (`gray_sync` XOR previous decode-stage Gray) > 1 sets `jump_err`.
  - 0 or 1 changed bits is legal.
- **`jump_err` persistence:** stays set until `clr_err` or `reset`. If a set and `clr_err` occur in the same cycle, the set wins.
- **Non-sample outputs:** `delta`, `inc` and `wrap` are meaningful only while `bin_valid` = 1, and are 0 otherwise.

## Timing
- **Gray path:** a `gray_in` value stable before rising edge N appears on `gray_sync` after edge N+SYNC_STAGES−1.
- **Binary path:** the same value appears on `bin_out`, `delta`, `inc` and `wrap` after edge N+SYNC_STAGES.
- **Throughput:** one sample per clock, no stalls, no handshake.
- **`wrap`:** high for exactly one cycle per wrap.
- **`jump_err`:** rises in the same cycle as the offending `bin_out` update.
- **`clr_err`:** takes effect at the next edge.
- **Reset mid-operation:** outputs drop immediately. After release the fill sequence restarts, so `bin_valid` returns SYNC_STAGES+1 edges later and the first sample is again treated as first.
- **Gray input changing every cycle:** supported. Each synchronized value is decoded and `inc` = 1 each cycle.

## Configuration
- `GRAY_DEC_ERR_CHECK_EN`
- **Defined:** popcount comparator and `jump_err` register present; `clr_err` active.
- **Undefined:** comparator and register are not built; `jump_err` is tied to 0 and `clr_err` is ignored. All other behaviour is identical.

## Test plan
All scenarios use WIDTH=4, SYNC_STAGES=2.
- **Reset and fill:** hold `reset` 1 with `gray_in` = 0101, release.
  - All outputs are 0 during reset.
  - `bin_valid` rises after the 3rd edge with `bin_out` = 0110, `delta` = 0, `inc` = 0.
- **Legal counting:** drive Gray 0000→0001→0011→0010, one step per clock.
  - `bin_out` follows 0,1,2,3 with a 3-cycle lag.
  - `inc` = 1 each step and `jump_err` stays 0.
- **Wrap:** step Gray 1000→0000.
  - `bin_out` goes 15→0 with `delta` = 1, `inc` = 1, and `wrap` high for one cycle.
- **Illegal jump** (macro defined): after Gray 0011 (bin 2), drive 1001.
  - `bin_out` = 14, `delta` = 12, `inc` = 0.
  - `jump_err` = 1 and stays 1 until `clr_err` pulses; `jump_err` = 0 the next cycle.
- **Simultaneous set and clear:** hold `clr_err` = 1 during a 2-bit Gray jump.
  - `jump_err` ends at 1.
  - With the macro undefined, `jump_err` stays 0 throughout.
- **Mid-run reset:** assert `reset` while counting.
  - Outputs go to 0 immediately.
  - After release, `bin_valid` takes 3 edges to return, and the first post-reset sample has `delta` = 0.

Source files
------------

// File: rtl/gray_count_decoder.sv
`default_nettype none
// ============================================================================
// Module   : gray_count_decoder
// Brief    : Synchronizes a Gray-coded count, decodes it to binary and reports
//            increment, wrap and illegal multi-bit Gray jumps.
//            Optional macro GRAY_DEC_ERR_CHECK_EN builds the jump_err checker.
// Revision : 1.0 - initial release
// ============================================================================
module gray_count_decoder #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             clr_err,
    output logic [WIDTH-1:0] gray_sync,
    output logic [WIDTH-1:0] bin_out,
    output logic             bin_valid,
    output logic [WIDTH-1:0] delta,
    output logic             inc,
    output logic             wrap,
    output logic             jump_err
);

    localparam int                c_FILL_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [c_FILL_W-1:0] c_FILL_LAST = c_FILL_W'(SYNC_STAGES);
    localparam logic [c_FILL_W-1:0] c_FILL_DONE = c_FILL_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0]                  w_gray;
    logic [WIDTH-1:0]                  w_bin;
    logic [WIDTH-1:0]                  w_delta;
    logic [c_FILL_W-1:0]               r_fill;
    logic                              r_have_prev;
    logic                              r_bin_valid;
    logic [WIDTH-1:0]                  r_bin_out;
    logic [WIDTH-1:0]                  r_delta;
    logic                              r_inc;
    logic                              r_wrap;

    // Plain flop chain: no logic between stages so metastability can settle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_gray = r_sync[SYNC_STAGES-1];

    // Each binary bit is the XOR of all Gray bits at and above it.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_decode
            assign w_bin[i] = ^w_gray[WIDTH-1:i];
        end
    endgenerate

    assign w_delta = w_bin - r_bin_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fill      <= '0;
            r_have_prev <= 1'b0;
            r_bin_valid <= 1'b0;
            r_bin_out   <= '0;
            r_delta     <= '0;
            r_inc       <= 1'b0;
            r_wrap      <= 1'b0;
        end else begin
            r_bin_out <= w_bin;
            if (r_fill != c_FILL_DONE) begin
                r_fill <= r_fill + 1'b1;
            end
            // The edge that loads the first real sample also arms the delta path.
            if (r_fill == c_FILL_LAST) begin
                r_bin_valid <= 1'b1;
                r_have_prev <= 1'b1;
            end
            if (r_have_prev) begin
                r_delta <= w_delta;
                r_inc   <= (w_delta == WIDTH'(1));
                r_wrap  <= (&r_bin_out) && (w_bin == '0);
            end else begin
                r_delta <= '0;
                r_inc   <= 1'b0;
                r_wrap  <= 1'b0;
            end
        end
    end

`ifdef GRAY_DEC_ERR_CHECK_EN
    logic [WIDTH-1:0] r_gray_prev;
    logic [WIDTH-1:0] w_diff;
    logic             w_jump;
    logic             r_jump_err;

    // More than one bit set <=> clearing the lowest set bit leaves a nonzero value.
    assign w_diff = w_gray ^ r_gray_prev;
    assign w_jump = r_have_prev && ((w_diff & (w_diff - WIDTH'(1))) != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gray_prev <= '0;
            r_jump_err  <= 1'b0;
        end else begin
            r_gray_prev <= w_gray;
            if (w_jump) begin
                r_jump_err <= 1'b1;
            end else if (clr_err) begin
                r_jump_err <= 1'b0;
            end
        end
    end

    assign jump_err = r_jump_err;
`else
    logic w_unused_clr_err;

    assign w_unused_clr_err = clr_err;
    assign jump_err         = 1'b0;
`endif

    assign gray_sync = w_gray;
    assign bin_out   = r_bin_out;
    assign bin_valid = r_bin_valid;
    assign delta     = r_delta;
    assign inc       = r_inc;
    assign wrap      = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_gray_count_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_gray_count_decoder
// Brief    : Directed self-checking bench for gray_count_decoder (WIDTH=4,
//            SYNC_STAGES=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gray_count_decoder;

`ifdef GRAY_DEC_ERR_CHECK_EN
    localparam bit c_ERR_EN = 1'b1;
`else
    localparam bit c_ERR_EN = 1'b0;
`endif
    localparam int c_N = 17;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] gray_in = 4'b0101;
    logic       clr_err = 1'b0;
    logic [3:0] gray_sync;
    logic [3:0] bin_out;
    logic       bin_valid;
    logic [3:0] delta;
    logic       inc;
    logic       wrap;
    logic       jump_err;

    int n_total = 0;
    int n_bad   = 0;

    // Stream from bin 6 upward through the wrap, back down one, then an illegal jump.
    logic [3:0] s_gray  [c_N] = '{4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010,
                                  4'b1011, 4'b1001, 4'b1000, 4'b0000, 4'b0001, 4'b0011,
                                  4'b0010, 4'b0011, 4'b1001, 4'b1001, 4'b1001};
    logic [3:0] s_bin   [c_N] = '{4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14,
                                  4'd15, 4'd0, 4'd1, 4'd2, 4'd3, 4'd2, 4'd14, 4'd14, 4'd14};
    logic [3:0] s_delta [c_N] = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1,
                                  4'd1, 4'd1, 4'd1, 4'd1, 4'd15, 4'd12, 4'd0, 4'd0};
    logic       s_inc   [c_N] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    logic       s_wrap  [c_N] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    logic       s_err   [c_N] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};

    gray_count_decoder #(
        .WIDTH       (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .gray_in   (gray_in),
        .clr_err   (clr_err),
        .gray_sync (gray_sync),
        .bin_out   (bin_out),
        .bin_valid (bin_valid),
        .delta     (delta),
        .inc       (inc),
        .wrap      (wrap),
        .jump_err  (jump_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " gray_sync"}, gray_sync, 0);
        check({tag, " bin_out"},   bin_out,   0);
        check({tag, " bin_valid"}, bin_valid, 0);
        check({tag, " delta"},     delta,     0);
        check({tag, " inc"},       inc,       0);
        check({tag, " wrap"},      wrap,      0);
        check({tag, " jump_err"},  jump_err,  0);
    endtask

    initial begin
        int idx;

        // Reset and fill
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();
        check("fill1 valid", bin_valid, 0);
        tick();
        check("fill2 valid", bin_valid, 0);
        check("fill2 gray_sync", gray_sync, 4'b0101);
        tick();
        check("fill3 valid", bin_valid, 1);
        check("fill3 bin", bin_out, 6);
        check("fill3 delta", delta, 0);
        check("fill3 inc", inc, 0);
        tick();
        check("steady delta", delta, 0);
        check("steady inc", inc, 0);
        check("steady wrap", wrap, 0);

        // Counting, wrap, down-step and illegal jump
        for (int k = 0; k <= c_N + 1; k++) begin
            gray_in = s_gray[(k < c_N) ? k : c_N - 1];
            tick();
            if (k >= 1) begin
                idx = (k - 1 < c_N) ? k - 1 : c_N - 1;
                check($sformatf("row%0d gray_sync", idx), gray_sync, s_gray[idx]);
            end
            if (k >= 2) begin
                idx = k - 2;
                check($sformatf("row%0d bin", idx), bin_out, s_bin[idx]);
                check($sformatf("row%0d delta", idx), delta, s_delta[idx]);
                check($sformatf("row%0d inc", idx), inc, s_inc[idx]);
                check($sformatf("row%0d wrap", idx), wrap, s_wrap[idx]);
                check($sformatf("row%0d jump_err", idx), jump_err, s_err[idx] & c_ERR_EN);
            end
        end

        // Clear
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("clr jump_err", jump_err, 0);
        tick();
        check("after clr jump_err", jump_err, 0);

        // 2-bit jump 1001 -> 1111 while clr_err is high
        gray_in = 4'b1111;
        tick();
        tick();
        check("pre-jump jump_err", jump_err, 0);
        check("pre-jump bin", bin_out, 14);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("set+clr bin", bin_out, 10);
        check("set+clr delta", delta, 12);
        check("set+clr inc", inc, 0);
        check("set+clr jump_err", jump_err, c_ERR_EN);
        tick();
        check("held jump_err", jump_err, c_ERR_EN);
        check("held delta", delta, 0);

        // Mid-run reset
        gray_in = 4'b1110;
        tick();
        gray_in = 4'b1010;
        tick();
        #2 reset = 1'b1;
        #1;
        check_all_zero("midreset");
        gray_in = 4'b1011;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("refill1 valid", bin_valid, 0);
        tick();
        check("refill2 valid", bin_valid, 0);
        tick();
        check("refill3 valid", bin_valid, 1);
        check("refill3 bin", bin_out, 13);
        check("refill3 delta", delta, 0);
        check("refill3 inc", inc, 0);
        check("refill3 jump_err", jump_err, 0);
        gray_in = 4'b1001;
        repeat (3) tick();
        check("post-reset bin", bin_out, 14);
        check("post-reset delta", delta, 1);
        check("post-reset inc", inc, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
